compute_s: RTL

- Second matrix multiply of the 8x8 2D IDCT: S = C^T x T.
- Reads the 8x8 signed T block from the dual-port T RAM and multiplies it by the fixed 8x8 cosine matrix.
- Scales, clips each result to 8 bits and packs three vertically adjacent pixels per 32-bit word into the Sp RAM.
- The SRAM write-out stage then reads Sp and stores it to external SRAM.

---
 rtl/compute_s.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/compute_s.sv
// compute_s: second IDCT matrix multiply S = C^T x T, clipped to 8 bits and packed 3 pixels/word into Sp RAM.
// Optional build macro COMPUTE_S_CLIP_COUNT_EN adds the clip_count output.
module compute_s #(
  parameter int T_BASE = 0,
  parameter int SHIFT  = 16
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        start,
  output logic [7:0]  T_addr_a,
  input  logic [31:0] T_data_a,
  output logic [7:0]  T_addr_b,
  input  logic [31:0] T_data_b,
  output logic [7:0]  Sp_addr,
  output logic [31:0] Sp_wdata,
  output logic        Sp_wen,
  output logic        busy,
`ifdef COMPUTE_S_CLIP_COUNT_EN
  output logic        done,
  output logic [6:0]  clip_count
`else
  output logic        done
`endif
);

  localparam logic [7:0] T_BASE8 = T_BASE[7:0];

  // Cosine matrix, entry C[k][n] at index 8k+n.
  localparam logic signed [15:0] COS_ROM [0:63] = '{
    16'sd1448,  16'sd1448,  16'sd1448,  16'sd1448,  16'sd1448,  16'sd1448,  16'sd1448,  16'sd1448,
    16'sd2008,  16'sd1702,  16'sd1137,  16'sd399,  -16'sd399,  -16'sd1137, -16'sd1702, -16'sd2008,
    16'sd1892,  16'sd783,  -16'sd783,  -16'sd1892, -16'sd1892, -16'sd783,   16'sd783,   16'sd1892,
    16'sd1702, -16'sd399,  -16'sd2008, -16'sd1137,  16'sd1137,  16'sd2008,  16'sd399,  -16'sd1702,
    16'sd1448, -16'sd1448, -16'sd1448,  16'sd1448,  16'sd1448, -16'sd1448, -16'sd1448,  16'sd1448,
    16'sd1137, -16'sd2008,  16'sd399,   16'sd1702, -16'sd1702, -16'sd399,   16'sd2008, -16'sd1137,
    16'sd783,  -16'sd1892,  16'sd1892, -16'sd783,  -16'sd783,   16'sd1892, -16'sd1892,  16'sd783,
    16'sd399,  -16'sd1137,  16'sd1702, -16'sd2008,  16'sd2008, -16'sd1702,  16'sd1137, -16'sd399
  };

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEADIN,
    S_MAC,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t state_reg, state_next;

  // MAC index layout: {c[2:0], r[2:0], kp[1:0]}
  logic [7:0] idx_reg;
  logic       issue_en;
  logic [7:0] issue_idx;

  logic       s0_valid_reg, s1_valid_reg, s2_valid_reg, s3_valid_reg;
  logic [7:0] s0_idx_reg, s1_idx_reg, s2_idx_reg;
  logic [5:0] s3_pix_reg;

  logic signed [15:0] coef_a, coef_b;
  logic signed [47:0] prod_a_reg, prod_b_reg, acc_reg;
  logic signed [47:0] acc_shift;

  logic [23:0] pack_reg;
  logic [23:0] merged;
  logic [7:0]  pixel;
  logic        clipped;
  logic [1:0]  lane;
  logic [1:0]  row;
  logic [2:0]  pix_r;
  logic [2:0]  pix_c;
  logic        word_end;
  logic [7:0]  word_addr;
  logic        pipe_busy;

  assign pipe_busy = s0_valid_reg | s1_valid_reg | s2_valid_reg | s3_valid_reg;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) state_reg <= S_IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    issue_en   = 1'b0;
    issue_idx  = idx_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          issue_en   = 1'b1;
          issue_idx  = 8'd0;
          state_next = S_LEADIN;
        end
      end
      S_LEADIN: begin
        issue_en   = 1'b1;
        state_next = S_MAC;
      end
      S_MAC: begin
        issue_en = 1'b1;
        if (idx_reg == 8'd255) state_next = S_FLUSH;
      end
      S_FLUSH: begin
        if (!pipe_busy) state_next = S_DONE;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign busy = (state_reg == S_LEADIN) || (state_reg == S_MAC) || (state_reg == S_FLUSH);
  assign done = (state_reg == S_DONE);

  // Address issue: port A reads row k=2kp, port B row k=2kp+1 of column c.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      idx_reg      <= 8'd0;
      s0_valid_reg <= 1'b0;
      s0_idx_reg   <= 8'd0;
      T_addr_a     <= 8'd0;
      T_addr_b     <= 8'd0;
    end else begin
      s0_valid_reg <= issue_en;
      if (issue_en) begin
        T_addr_a   <= T_BASE8 + {2'b00, issue_idx[1:0], 1'b0, issue_idx[7:5]};
        T_addr_b   <= T_BASE8 + {2'b00, issue_idx[1:0], 1'b1, issue_idx[7:5]};
        s0_idx_reg <= issue_idx;
        idx_reg    <= issue_idx + 8'd1;
      end
    end
  end

  assign coef_a = COS_ROM[{s1_idx_reg[1:0], 1'b0, s1_idx_reg[4:2]}];
  assign coef_b = COS_ROM[{s1_idx_reg[1:0], 1'b1, s1_idx_reg[4:2]}];

  // RAM-latency stage, registered product stage, then accumulate.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      s1_valid_reg <= 1'b0;
      s1_idx_reg   <= 8'd0;
      s2_valid_reg <= 1'b0;
      s2_idx_reg   <= 8'd0;
      s3_valid_reg <= 1'b0;
      s3_pix_reg   <= 6'd0;
      prod_a_reg   <= 48'sd0;
      prod_b_reg   <= 48'sd0;
      acc_reg      <= 48'sd0;
    end else begin
      s1_valid_reg <= s0_valid_reg;
      s1_idx_reg   <= s0_idx_reg;
      s2_valid_reg <= s1_valid_reg;
      s2_idx_reg   <= s1_idx_reg;
      if (s1_valid_reg) begin
        prod_a_reg <= 48'($signed(T_data_a)) * 48'(coef_a);
        prod_b_reg <= 48'($signed(T_data_b)) * 48'(coef_b);
      end
      s3_valid_reg <= s2_valid_reg && (s2_idx_reg[1:0] == 2'd3);
      s3_pix_reg   <= s2_idx_reg[7:2];
      if (s2_valid_reg) begin
        acc_reg <= ((s2_idx_reg[1:0] == 2'd0) ? 48'sd0 : acc_reg) + prod_a_reg + prod_b_reg;
      end
    end
  end

  assign pix_r = s3_pix_reg[2:0];
  assign pix_c = s3_pix_reg[5:3];

  always_comb begin
    acc_shift = acc_reg >>> SHIFT;
    pixel     = acc_shift[7:0];
    clipped   = 1'b0;
    if (acc_shift < 48'sd0) begin
      pixel   = 8'd0;
      clipped = 1'b1;
    end else if (acc_shift > 48'sd255) begin
      pixel   = 8'd255;
      clipped = 1'b1;
    end
    lane = 2'd0;
    row  = 2'd0;
    case (pix_r)
      3'd0: begin lane = 2'd0; row = 2'd0; end
      3'd1: begin lane = 2'd1; row = 2'd0; end
      3'd2: begin lane = 2'd2; row = 2'd0; end
      3'd3: begin lane = 2'd0; row = 2'd1; end
      3'd4: begin lane = 2'd1; row = 2'd1; end
      3'd5: begin lane = 2'd2; row = 2'd1; end
      3'd6: begin lane = 2'd0; row = 2'd2; end
      default: begin lane = 2'd1; row = 2'd2; end
    endcase
    merged    = pack_reg | (24'(pixel) << {lane, 3'b000});
    word_end  = (lane == 2'd2) || (pix_r == 3'd7);
    word_addr = {4'b0000, pix_c, 1'b0} + {5'b00000, pix_c} + {6'b000000, row};
  end

  // Pack three vertically adjacent pixels; the last word of a column holds rows 6-7 only.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      pack_reg <= 24'd0;
      Sp_wen   <= 1'b0;
      Sp_addr  <= 8'd0;
      Sp_wdata <= 32'd0;
    end else begin
      Sp_wen <= 1'b0;
      if (s3_valid_reg) begin
        if (word_end) begin
          Sp_wen   <= 1'b1;
          Sp_addr  <= word_addr;
          Sp_wdata <= {8'h00, merged};
          pack_reg <= 24'd0;
        end else begin
          pack_reg <= merged;
        end
      end
    end
  end

`ifdef COMPUTE_S_CLIP_COUNT_EN
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      clip_count <= 7'd0;
    end else if (state_reg == S_IDLE && start) begin
      clip_count <= 7'd0;
    end else if (s3_valid_reg && clipped) begin
      clip_count <= clip_count + 7'd1;
    end
  end
`endif

endmodule
